// File: rtl/mem_arb_pkg.sv
// Shared widths, state encoding and lane type for the two-lane memory arbiter.
package mem_arb_pkg;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic lane_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-lane grant selection: a lone requester always wins, an ordering hazard
// forces lane 0, otherwise the lane not granted last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       hazard,
  output logic [1:0] grant,
  output lane_t      ptr
);

  lane_t ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (hazard || !ptr_q) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase

    // pointer names the lane favoured on the next contested grant
    ptr_d = ptr_q;
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-lane memory arbiter: grant, one-cycle memory strobe, response pulse.
// Optional out-of-range address check enabled by MEM_ARB_RANGE_CHK_EN.
//
// state  | meaning
// IDLE   | nothing in flight; evaluates grants
// ACCESS | drives one memory strobe for the latched request
// RESP   | responds to the granted lane and evaluates the next grant
module mem_arbiter #(
  parameter int DW    = mem_arb_pkg::DW,
  parameter int AW    = mem_arb_pkg::AW,
  parameter int DEPTH = mem_arb_pkg::DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_is_st,
  input  logic [2*DW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      req_ready,
  output logic [1:0]      resp_valid,
  output logic [2*DW-1:0] resp_rdata,
  output logic            mem_isld,
  output logic            mem_isst,
  output logic [DW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            err
);
  import mem_arb_pkg::*;

  state_e        state_q, state_d;
  lane_t         lane_q, lane_d;
  logic          is_st_q, is_st_d;
  logic          oor_q, oor_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [DW-1:0] a0, a1, g_addr, g_wdata;
  logic [1:0]    arb_valid, grant;
  logic          hazard, can_grant;
  lane_t         g_lane, rr_ptr_unused;
  logic          addr_unused;

  assign a0 = req_addr[DW-1:0];
  assign a1 = req_addr[2*DW-1:DW];

  assign can_grant = !rst && (state_q == IDLE || state_q == RESP);
  assign arb_valid = req_valid & {2{can_grant}};
  assign hazard    = (a0[AW-1:0] == a1[AW-1:0]) && (|req_is_st);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .valid  (arb_valid),
    .hazard (hazard),
    .grant  (grant),
    .ptr    (rr_ptr_unused)
  );

  assign g_lane  = grant[1];
  assign g_addr  = g_lane ? a1 : a0;
  assign g_wdata = g_lane ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign addr_unused = ^g_addr[DW-1:AW];

  always_comb begin
    state_d     = (state_q == ACCESS) ? RESP : IDLE;
    lane_d      = lane_q;
    is_st_d     = is_st_q;
    oor_d       = oor_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (|grant) begin
      state_d     = ACCESS;
      lane_d      = g_lane;
      is_st_d     = req_is_st[g_lane];
      mem_wdata_d = g_wdata;
`ifdef MEM_ARB_RANGE_CHK_EN
      oor_d       = (g_addr >= DW'(DEPTH));
      mem_addr_d  = g_addr;
`else
      // addresses wrap onto the implemented memory
      oor_d       = 1'b0;
      mem_addr_d  = {{(DW-AW){1'b0}}, g_addr[AW-1:0]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= 1'b0;
      is_st_q     <= 1'b0;
      oor_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      is_st_q     <= is_st_d;
      oor_q       <= oor_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = grant;
  assign busy      = (state_q != IDLE);
  assign mem_isld  = (state_q == ACCESS) && !is_st_q && !oor_q;
  assign mem_isst  = (state_q == ACCESS) && is_st_q && !oor_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // a reset landing in RESP abandons the response as well
  always_comb begin
    resp_valid = 2'b00;
    resp_rdata = '0;
    if (state_q == RESP && !rst) begin
      resp_valid[lane_q] = 1'b1;
      if (!is_st_q && !oor_q) begin
        if (lane_q) resp_rdata[2*DW-1:DW] = mem_rdata;
        else        resp_rdata[DW-1:0]    = mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_RANGE_CHK_EN
  assign err = (state_q == RESP) && oor_q && !rst;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus a reset-abort sequence.
module tb_mem_arbiter;

`ifdef MEM_ARB_RANGE_CHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_is_st, req_ready, resp_valid;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        mem_isld, mem_isst, busy, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_is_st  (req_is_st),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_isld   (mem_isld),
    .mem_isst   (mem_isst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic [1:0]  valid, is_st;
    logic [15:0] a0, a1, w0, w1, rd;
    logic [1:0]  ready, rv;
    logic [31:0] rdata;
    logic        isld, isst, busy, err;
    logic [15:0] maddr, mwd;
  } vec_t;

  localparam int NV = 24;
  vec_t tv[NV];

  function automatic vec_t mk(
      logic [1:0] valid, logic [1:0] is_st, logic [15:0] a0, logic [15:0] a1,
      logic [15:0] w0, logic [15:0] w1, logic [15:0] rd,
      logic [1:0] ready, logic [1:0] rv, logic [31:0] rdata,
      logic isld, logic isst, logic bsy, logic e, logic [15:0] maddr, logic [15:0] mwd);
    vec_t v;
    v.valid = valid; v.is_st = is_st; v.a0 = a0; v.a1 = a1;
    v.w0 = w0; v.w1 = w1; v.rd = rd;
    v.ready = ready; v.rv = rv; v.rdata = rdata;
    v.isld = isld; v.isst = isst; v.busy = bsy; v.err = e;
    v.maddr = maddr; v.mwd = mwd;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  initial begin
    // lane 0 load at addr 3, data BEEF
    tv[0]  = mk(2'b01, 2'b00, 16'd3, 16'd0, 16'h0, 16'h0,    16'h0,    2'b01, 2'b00, 32'h0,        0, 0, 0, 0, 16'd0, 16'h0);
    tv[1]  = mk(2'b00, 2'b00, 16'd3, 16'd0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        1, 0, 1, 0, 16'd3, 16'h0);
    tv[2]  = mk(2'b00, 2'b00, 16'd3, 16'd0, 16'h0, 16'h0,    16'hBEEF, 2'b00, 2'b01, 32'h0000BEEF, 0, 0, 1, 0, 16'd3, 16'h0);
    tv[3]  = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        0, 0, 0, 0, 16'd3, 16'h0);
    // hazard: lane 0 load / lane 1 store at addr 7, pointer favours lane 1
    tv[4]  = mk(2'b11, 2'b10, 16'd7, 16'd7, 16'h0, 16'h1234, 16'h0,    2'b01, 2'b00, 32'h0,        0, 0, 0, 0, 16'd3, 16'h0);
    tv[5]  = mk(2'b10, 2'b10, 16'd7, 16'd7, 16'h0, 16'h1234, 16'h0,    2'b00, 2'b00, 32'h0,        1, 0, 1, 0, 16'd7, 16'h0);
    tv[6]  = mk(2'b10, 2'b10, 16'd7, 16'd7, 16'h0, 16'h1234, 16'h5555, 2'b10, 2'b01, 32'h00005555, 0, 0, 1, 0, 16'd7, 16'h0);
    tv[7]  = mk(2'b00, 2'b10, 16'd7, 16'd7, 16'h0, 16'h1234, 16'h0,    2'b00, 2'b00, 32'h0,        0, 1, 1, 0, 16'd7, 16'h1234);
    tv[8]  = mk(2'b00, 2'b10, 16'd7, 16'd7, 16'h0, 16'h1234, 16'hFFFF, 2'b00, 2'b10, 32'h0,        0, 0, 1, 0, 16'd7, 16'h1234);
    tv[9]  = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        0, 0, 0, 0, 16'd7, 16'h1234);
    // both lanes loading 4 and 9, round-robin 0,1,0,1
    tv[10] = mk(2'b11, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0,    2'b01, 2'b00, 32'h0,        0, 0, 0, 0, 16'd7, 16'h1234);
    tv[11] = mk(2'b11, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        1, 0, 1, 0, 16'd4, 16'h0);
    tv[12] = mk(2'b11, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0A0A, 2'b10, 2'b01, 32'h00000A0A, 0, 0, 1, 0, 16'd4, 16'h0);
    tv[13] = mk(2'b11, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        1, 0, 1, 0, 16'd9, 16'h0);
    tv[14] = mk(2'b11, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0B0B, 2'b01, 2'b10, 32'h0B0B0000, 0, 0, 1, 0, 16'd9, 16'h0);
    tv[15] = mk(2'b11, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        1, 0, 1, 0, 16'd4, 16'h0);
    tv[16] = mk(2'b11, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0C0C, 2'b10, 2'b01, 32'h00000C0C, 0, 0, 1, 0, 16'd4, 16'h0);
    tv[17] = mk(2'b00, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        1, 0, 1, 0, 16'd9, 16'h0);
    tv[18] = mk(2'b00, 2'b00, 16'd4, 16'd9, 16'h0, 16'h0,    16'h0D0D, 2'b00, 2'b10, 32'h0D0D0000, 0, 0, 1, 0, 16'd9, 16'h0);
    tv[19] = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        0, 0, 0, 0, 16'd9, 16'h0);
    // lane 0 load from addr 40: wraps to 8, or range error when checked
    tv[20] = mk(2'b01, 2'b00, 16'd40, 16'd0, 16'h0, 16'h0,   16'h0,    2'b01, 2'b00, 32'h0,        0, 0, 0, 0, 16'd9, 16'h0);
    tv[21] = mk(2'b00, 2'b00, 16'd40, 16'd0, 16'h0, 16'h0,   16'h0,    2'b00, 2'b00, 32'h0,        !RC, 0, 1, 0, RC ? 16'd40 : 16'd8, 16'h0);
    tv[22] = mk(2'b00, 2'b00, 16'd40, 16'd0, 16'h0, 16'h0,   16'h7777, 2'b00, 2'b01, RC ? 32'h0 : 32'h00007777, 0, 0, 1, RC, RC ? 16'd40 : 16'd8, 16'h0);
    tv[23] = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 32'h0,        0, 0, 0, 0, RC ? 16'd40 : 16'd8, 16'h0);

    // reset with a request pending: everything must stay quiet
    rst = 1'b1; req_valid = 2'b01; req_is_st = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", -1, 32'(req_ready), 32'h0);
    chk("rst_resp_valid", -1, 32'(resp_valid), 32'h0);
    chk("rst_rdata", -1, resp_rdata, 32'h0);
    chk("rst_strobes", -1, 32'({mem_isld, mem_isst}), 32'h0);
    chk("rst_mem_addr", -1, 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", -1, 32'(mem_wdata), 32'h0);
    chk("rst_busy_err", -1, 32'({busy, err}), 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = tv[i].valid;
      req_is_st = tv[i].is_st;
      req_addr  = {tv[i].a1, tv[i].a0};
      req_wdata = {tv[i].w1, tv[i].w0};
      mem_rdata = tv[i].rd;
      @(negedge clk);
      chk("req_ready", i, 32'(req_ready), 32'(tv[i].ready));
      chk("resp_valid", i, 32'(resp_valid), 32'(tv[i].rv));
      chk("resp_rdata", i, resp_rdata, tv[i].rdata);
      chk("mem_isld", i, 32'(mem_isld), 32'(tv[i].isld));
      chk("mem_isst", i, 32'(mem_isst), 32'(tv[i].isst));
      chk("busy", i, 32'(busy), 32'(tv[i].busy));
      chk("err", i, 32'(err), 32'(tv[i].err));
      chk("mem_addr", i, 32'(mem_addr), 32'(tv[i].maddr));
      chk("mem_wdata", i, 32'(mem_wdata), 32'(tv[i].mwd));
    end

    // reset while a store strobe is on the bus abandons the access
    @(posedge clk);
    #1;
    req_valid = 2'b10; req_is_st = 2'b10;
    req_addr = {16'd2, 16'd0}; req_wdata = {16'h00AA, 16'h0}; mem_rdata = 16'h0;
    @(negedge clk);
    chk("abort_ready", 100, 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_isst", 101, 32'(mem_isst), 32'h1);
    chk("abort_addr", 101, 32'(mem_addr), 32'h2);
    chk("abort_wdata", 101, 32'(mem_wdata), 32'hAA);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid", 102, 32'(resp_valid), 32'h0);
    chk("abort_busy", 102, 32'(busy), 32'h0);
    chk("abort_strobes", 102, 32'({mem_isld, mem_isst}), 32'h0);
    chk("abort_mem_addr", 102, 32'(mem_addr), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_no_late_resp", 103, 32'(resp_valid), 32'h0);
    chk("abort_idle", 103, 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
